letter_renderer: RTL and testbench



---
 rtl/letter_renderer.sv | 147 ++++++++++++++
 tb/tb_letter_renderer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/letter_renderer.sv
// Letter renderer: clears a back buffer, ORs up to 8 two-half 3x5 glyphs into it, then commits it atomically.
// Optional macro RENDER_CLIP_EN: per-row clipping at the screen bottom instead of whole-channel hiding.
module letter_renderer #(
    parameter int COLS     = 40,
    parameter int ROWS     = 30,
    parameter int N_CH     = 3,
    parameter int X_BASE   = 6,
    parameter int X_STEP   = 10,
    parameter int Y_OFFSET = 2,
    parameter int Y_LIMIT  = 22
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [N_CH*30-1:0]     glyphs,
    input  logic [N_CH*5-1:0]      ypos,
    output logic                   busy,
    output logic                   done,
    output logic [ROWS*COLS-1:0]   framebuffer
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CLEAR  = 2'd1;
    localparam logic [1:0] DRAW   = 2'd2;
    localparam logic [1:0] COMMIT = 2'd3;

    generate
        if (N_CH < 1 || N_CH > 8) begin : g_bad_nch
            $error("letter_renderer: N_CH must be in 1..8");
        end
        if (X_BASE + (N_CH - 1) * X_STEP + 7 > COLS - 1) begin : g_bad_cols
            $error("letter_renderer: rightmost channel does not fit in COLS");
        end
    endgenerate

    logic [1:0]                   state_reg;
    logic [N_CH*30-1:0]           glyph_reg;
    logic [N_CH*5-1:0]            ypos_reg;
    logic [ROWS-1:0][COLS-1:0]    back_reg;
    logic [RW-1:0]                clr_row_reg;
    logic [CW-1:0]                ch_reg;
    logic [2:0]                   gr_reg;

    logic [29:0] ch_glyph [N_CH];
    logic [4:0]  ch_ypos  [N_CH];

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_unpack
            assign ch_glyph[gi] = glyph_reg[gi*30 +: 30];
            assign ch_ypos[gi]  = ypos_reg[gi*5 +: 5];
        end
    endgenerate

    logic [29:0]      glyph_sel;
    logic [4:0]       ypos_sel;
    logic [2:0]       left_bits;
    logic [2:0]       right_bits;
    int               bit_lo;
    int               base_sel;
    int               target_row;
    logic [COLS-1:0]  row_mask;
    logic             draw_en;
    logic [RW-1:0]    row_idx;

    // Current (channel, glyph row) pair expanded into a one-row OR mask.
    always_comb begin
        glyph_sel  = ch_glyph[ch_reg];
        ypos_sel   = ch_ypos[ch_reg];
        bit_lo     = 27 - 3 * int'(gr_reg);
        left_bits  = glyph_sel[bit_lo +: 3];
        right_bits = glyph_sel[(bit_lo - 15) +: 3];
        base_sel   = X_BASE + int'(ch_reg) * X_STEP;
        target_row = Y_OFFSET + int'(ypos_sel) + int'(gr_reg);
        row_mask   = (COLS'(left_bits) << base_sel) | (COLS'(right_bits) << (base_sel + 5));
        row_idx    = target_row[RW-1:0];
`ifdef RENDER_CLIP_EN
        draw_en    = (target_row < ROWS);
`else
        draw_en    = (int'(ypos_sel) < Y_LIMIT) && (target_row < ROWS);
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            glyph_reg   <= '0;
            ypos_reg    <= '0;
            back_reg    <= '0;
            clr_row_reg <= '0;
            ch_reg      <= '0;
            gr_reg      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            framebuffer <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        glyph_reg   <= glyphs;
                        ypos_reg    <= ypos;
                        clr_row_reg <= '0;
                        busy        <= 1'b1;
                        state_reg   <= CLEAR;
                    end
                end
                CLEAR: begin
                    back_reg[clr_row_reg] <= '0;
                    if (clr_row_reg == RW'(ROWS - 1)) begin
                        ch_reg    <= '0;
                        gr_reg    <= '0;
                        state_reg <= DRAW;
                    end else begin
                        clr_row_reg <= clr_row_reg + 1'b1;
                    end
                end
                DRAW: begin
                    if (draw_en) begin
                        back_reg[row_idx] <= back_reg[row_idx] | row_mask;
                    end
                    if (gr_reg == 3'd4) begin
                        gr_reg <= '0;
                        if (ch_reg == CW'(N_CH - 1)) begin
                            state_reg <= COMMIT;
                        end else begin
                            ch_reg <= ch_reg + 1'b1;
                        end
                    end else begin
                        gr_reg <= gr_reg + 1'b1;
                    end
                end
                COMMIT: begin
                    framebuffer <= back_reg;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state_reg   <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_letter_renderer.sv
// Directed bench for letter_renderer: default instance plus a 4-channel overlapping instance.
module tb_letter_renderer;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [89:0]   glyphs = '0;
    logic [14:0]   ypos = '0;
    logic          busy, done;
    logic [1199:0] framebuffer;

    logic          start2 = 1'b0;
    logic [119:0]  glyphs2 = '0;
    logic [19:0]   ypos2 = '0;
    logic          busy2, done2;
    logic [1199:0] framebuffer2;

    localparam logic [29:0] ONES = 30'h3FFFFFFF;
    localparam logic [29:0] PAT1 = {15'h4001, 15'h1004};

    letter_renderer dut (
        .clock(clock), .reset(reset), .start(start), .glyphs(glyphs), .ypos(ypos),
        .busy(busy), .done(done), .framebuffer(framebuffer)
    );

    letter_renderer #(.N_CH(4), .X_STEP(5)) dut2 (
        .clock(clock), .reset(reset), .start(start2), .glyphs(glyphs2), .ypos(ypos2),
        .busy(busy2), .done(done2), .framebuffer(framebuffer2)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_frame(input string tag, input logic [1199:0] got, input logic [1199:0] exp);
        for (int r = 0; r < 30; r++)
            check_val($sformatf("%s_row%0d", tag, r), 64'(got[r*40 +: 40]), 64'(exp[r*40 +: 40]));
    endtask

    function automatic logic [1199:0] blk(input logic [1199:0] f, input int row, input int col, input int n);
        for (int i = 0; i < n; i++) f[row*40 + col + i] = 1'b1;
        return f;
    endfunction

    // Called at a negedge: pulses start and waits (bounded) for done; lat counts edges after the start edge.
    task automatic run_frame(input bit sel, input string tag, output int lat);
        if (sel) start2 = 1'b1; else start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        start2 = 1'b0;
        check_val({tag, "_busy"}, 64'(sel ? busy2 : busy), 64'd1);
        lat = 0;
        while (!(sel ? done2 : done) && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        $display("frame %s latency %0d", tag, lat);
    endtask

    logic [1199:0] exp_fb;
    int            lat;
    int            n_done;
    int            done_at;

    initial begin
        repeat (3) @(negedge clock);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_frame("rst_fb", framebuffer, '0);

        // A: every glyph all ones at ypos 0, start on the very first edge after reset release
        glyphs = {ONES, ONES, ONES};
        ypos   = '0;
        reset  = 1'b0;
        run_frame(1'b0, "A", lat);
        check_val("A_latency", 64'(lat), 64'd46);
        check_val("A_busy_end", 64'(busy), 64'd0);
        exp_fb = '0;
        for (int r = 2; r <= 6; r++)
            for (int k = 0; k < 3; k++) begin
                exp_fb = blk(exp_fb, r, 6 + 10*k, 3);
                exp_fb = blk(exp_fb, r, 11 + 10*k, 3);
            end
        check_frame("A_fb", framebuffer, exp_fb);
        check_val("A_bits86_88", 64'(framebuffer[88:86]), 64'h7);
        check_val("A_bits91_93", 64'(framebuffer[93:91]), 64'h7);
        check_val("A_bits126_128", 64'(framebuffer[128:126]), 64'h7);
        check_val("A_bits89_90", 64'(framebuffer[90:89]), 64'h0);
        @(negedge clock);
        check_val("A_done_pulse", 64'(done), 64'd0);

        // B: channel 0 at ypos 21 lands on rows 23..27
        glyphs = {30'h0, 30'h0, ONES};
        ypos   = {5'd0, 5'd0, 5'd21};
        run_frame(1'b0, "B", lat);
        exp_fb = '0;
        for (int r = 23; r <= 27; r++) begin
            exp_fb = blk(exp_fb, r, 6, 3);
            exp_fb = blk(exp_fb, r, 11, 3);
        end
        check_frame("B_fb", framebuffer, exp_fb);

        // C: vertical boundary policy, with channel 1 checking bit-to-column order
        glyphs = {30'h0, PAT1, ONES};
        exp_fb = '0;
        exp_fb = blk(exp_fb, 2, 18, 1);
        exp_fb = blk(exp_fb, 2, 21, 1);
        exp_fb = blk(exp_fb, 6, 16, 1);
        exp_fb = blk(exp_fb, 6, 23, 1);
`ifdef RENDER_CLIP_EN
        ypos = {5'd0, 5'd0, 5'd26};
        for (int r = 28; r <= 29; r++) begin
            exp_fb = blk(exp_fb, r, 6, 3);
            exp_fb = blk(exp_fb, r, 11, 3);
        end
`else
        ypos = {5'd0, 5'd0, 5'd22};
`endif
        run_frame(1'b0, "C", lat);
        check_val("C_latency", 64'(lat), 64'd46);
        check_frame("C_fb", framebuffer, exp_fb);

        // D: a second start 10 cycles into the render, with new inputs, must be ignored
        glyphs = {ONES, 30'h0, 30'h0};
        ypos   = {5'd5, 5'd0, 5'd0};
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n_done = 0;
        done_at = -1;
        for (int n = 0; n < 120; n++) begin
            if (done) begin
                n_done++;
                done_at = n;
            end
            if (n == 9) begin
                glyphs = {ONES, ONES, ONES};
                ypos   = '0;
                start  = 1'b1;
            end else begin
                start  = 1'b0;
            end
            @(negedge clock);
        end
        $display("frame D latency %0d dones %0d", done_at, n_done);
        check_val("D_done_count", 64'(n_done), 64'd1);
        check_val("D_latency", 64'(done_at), 64'd46);
        exp_fb = '0;
        for (int r = 7; r <= 11; r++) begin
            exp_fb = blk(exp_fb, r, 26, 3);
            exp_fb = blk(exp_fb, r, 31, 3);
        end
        check_frame("D_fb", framebuffer, exp_fb);

        // E: reset in the middle of DRAW clears everything without waiting for an edge
        glyphs = {30'h0, PAT1, 30'h0};
        ypos   = '0;
        start  = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        repeat (35) @(negedge clock);
        check_val("E_busy_draw", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check_val("E_rst_busy", 64'(busy), 64'd0);
        check_val("E_rst_done", 64'(done), 64'd0);
        check_frame("E_rst_fb", framebuffer, '0);
        @(negedge clock);
        reset = 1'b0;
        run_frame(1'b0, "E", lat);
        check_val("E_latency", 64'(lat), 64'd46);
        exp_fb = '0;
        exp_fb = blk(exp_fb, 2, 18, 1);
        exp_fb = blk(exp_fb, 2, 21, 1);
        exp_fb = blk(exp_fb, 6, 16, 1);
        exp_fb = blk(exp_fb, 6, 23, 1);
        check_frame("E_fb", framebuffer, exp_fb);

        // F: 4 channels at pitch 5, channel 0 right half ORs with channel 1 left half
        glyphs2 = {30'h0, 30'h0, {15'h3000, 15'h0000}, {15'h0000, 15'h5000}};
        ypos2   = '0;
        @(negedge clock);
        run_frame(1'b1, "F", lat);
        check_val("F_latency", 64'(lat), 64'd51);
        check_val("F_bits91_93", 64'(framebuffer2[93:91]), 64'h7);
        exp_fb = '0;
        exp_fb = blk(exp_fb, 2, 11, 3);
        check_frame("F_fb", framebuffer2, exp_fb);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
